// File: rtl/dac_sample_scheduler.sv
// Paced round-robin arbiter that shares one SPI DAC writer between NUM_REQ sample producers.
// Optional macro DAC_TIMEOUT_EN adds a per-phase handshake timeout and the timeout_err_o port.
module dac_sample_scheduler #(
    parameter int NUM_REQ     = 2,
    parameter int RATE_DIV    = 100,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       enable_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [16*NUM_REQ-1:0]      req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [15:0]                dac_data_o,
    output logic                       dac_start_o,
    input  logic                       dac_idle_i,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       tick_overrun_o
`ifdef DAC_TIMEOUT_EN
    ,
    output logic                       timeout_err_o
`endif
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(RATE_DIV);
    localparam logic [GW-1:0] LAST_ID  = GW'(NUM_REQ - 1);
    localparam logic [CW-1:0] TICK_MAX = CW'(RATE_DIV - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || RATE_DIV < 40 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("dac_sample_scheduler: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_start;
    logic          w_start_nxt;
    logic [15:0]   r_data;
    logic [GW-1:0] r_grant;
    logic [CW-1:0] r_tick_cnt;
    logic          r_pending;
    logic          r_overrun;

    logic          w_wrap;
    logic          w_launch;
    logic          w_found;
    logic [GW-1:0] w_sel;
    logic [15:0]   w_sel_data;

`ifdef DAC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] PHASE_MAX = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] r_phase;
    logic          r_timeout;
    logic          w_timeout;
`endif

    assign w_wrap   = enable_i && (r_tick_cnt == TICK_MAX);
    assign w_launch = (r_state == IDLE) && r_pending && dac_idle_i && w_found;

    // A tick that wraps while the previous one is still unused is reported as lost,
    // unless that earlier tick is being consumed by a launch in the same cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_tick_cnt <= '0;
            r_pending  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (!enable_i) begin
                r_tick_cnt <= '0;
                r_pending  <= 1'b0;
            end else if (w_wrap) begin
                r_tick_cnt <= '0;
                r_pending  <= 1'b1;
                r_overrun  <= r_pending && !w_launch;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
                if (w_launch) begin
                    r_pending <= 1'b0;
                end
            end
        end
    end

    // First pass finds the lowest valid index above the last grant; the second pass
    // wraps around to the lowest valid index overall.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_grant;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid_i[k] && (k > int'(r_grant))) begin
                w_found = 1'b1;
                w_sel   = GW'(k);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid_i[k]) begin
                w_found = 1'b1;
                w_sel   = GW'(k);
            end
        end
    end

    always_comb begin
        w_sel_data  = '0;
        req_ready_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_sel == GW'(k)) begin
                w_sel_data     = req_data_i[16*k +: 16];
                req_ready_o[k] = w_launch;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = r_start;
`ifdef DAC_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_state_nxt = START;
                    w_start_nxt = 1'b1;
                end
            end
            START: begin
                if (!dac_idle_i) begin
                    w_state_nxt = BUSY;
                    w_start_nxt = 1'b0;
                end
            end
            BUSY: begin
                if (dac_idle_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_start_nxt = 1'b0;
            end
        endcase
`ifdef DAC_TIMEOUT_EN
        // A stalled handshake abandons the granted sample instead of retrying it.
        if ((r_state != IDLE) && (r_phase == PHASE_MAX)) begin
            w_state_nxt = IDLE;
            w_start_nxt = 1'b0;
            w_timeout   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
            r_start <= 1'b0;
            r_data  <= '0;
            r_grant <= LAST_ID;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            if (w_launch) begin
                r_data  <= w_sel_data;
                r_grant <= w_sel;
            end
        end
    end

`ifdef DAC_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_phase   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if ((w_state_nxt != r_state) || (r_state == IDLE)) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    assign timeout_err_o = r_timeout;
`endif

    assign dac_start_o    = r_start;
    assign dac_data_o     = r_data;
    assign grant_id_o     = r_grant;
    assign busy_o         = (r_state != IDLE);
    assign tick_overrun_o = r_overrun;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Self-checking bench for dac_sample_scheduler: a round-robin vector table plus
// hand-written sequences for idle ticks, disable, mid-transfer reset and timeout.
module tb_dac_sample_scheduler;

    localparam int NUM_REQ     = 2;
    localparam int RATE_DIV    = 100;
    localparam int TIMEOUT_CYC = 64;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        enable_i;
    logic [1:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [1:0]  req_ready_o;
    logic [15:0] dac_data_o;
    logic        dac_start_o;
    logic        dac_idle_i;
    logic        busy_o;
    logic [0:0]  grant_id_o;
    logic        tick_overrun_o;
`ifdef DAC_TIMEOUT_EN
    logic        timeout_err_o;
`endif

    typedef struct {
        logic [1:0]  valid;
        logic [0:0]  expGrant;
        logic [15:0] expData;
    } vec_t;

    typedef struct {
        logic [1:0]  ready;
        logic [0:0]  grant;
        logic [15:0] data;
    } exp_t;

    exp_t sbQ[$];
    exp_t curExp;
    vec_t tbl[10];

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int launchCount = 0;
    int lastLaunchCycle = 0;
    int overrunCount = 0;
    int prevOverrun = -1;
    int lastOverrun = -1;
    int timeoutCount = 0;
    int timeoutCycle = -1;
    bit pendCheck = 1'b0;
    bit wrStuck = 1'b0;
    int wrState = 0;
    int wrCnt = 0;
    int busyLen = 20;

    dac_sample_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .RATE_DIV   (RATE_DIV),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .enable_i      (enable_i),
        .req_valid_i   (req_valid_i),
        .req_data_i    (req_data_i),
        .req_ready_o   (req_ready_o),
        .dac_data_o    (dac_data_o),
        .dac_start_o   (dac_start_o),
        .dac_idle_i    (dac_idle_i),
        .busy_o        (busy_o),
        .grant_id_o    (grant_id_o),
        .tick_overrun_o(tick_overrun_o)
`ifdef DAC_TIMEOUT_EN
        ,
        .timeout_err_o (timeout_err_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        req_valid_i = v.valid;
        e.ready = 2'b01 << v.expGrant;
        e.grant = v.expGrant;
        e.data  = v.expData;
        sbQ.push_back(e);
    endtask

    task automatic waitLaunch(input string name, input int limit);
        int n0;
        bit ok;
        n0 = launchCount;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (launchCount != n0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput({name, "_no_launch"}, 0, 1);
    endtask

    task automatic waitIdle(input string name, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput({name, "_stuck_busy"}, 1, 0);
    endtask

    task automatic waitUntilCycle(input int target);
        while (cycleCnt < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Writer model: accepts start two samples after seeing it, stays busy busyLen cycles.
    always @(negedge clk) begin
        if (!reset_ni) begin
            dac_idle_i = 1'b1;
            wrState    = 0;
            wrCnt      = 0;
        end else if (!wrStuck) begin
            if (wrState == 0) begin
                if (dac_start_o) begin
                    wrCnt++;
                    if (wrCnt == 2) begin
                        dac_idle_i = 1'b0;
                        wrState    = 1;
                        wrCnt      = 0;
                    end
                end
            end else begin
                wrCnt++;
                if (wrCnt == busyLen) begin
                    dac_idle_i = 1'b1;
                    wrState    = 0;
                    wrCnt      = 0;
                end
            end
        end
    end

    // Scoreboard side: every launch pops one expectation; data/grant/start follow one cycle later.
    always @(negedge clk) begin
        if (pendCheck) begin
            pendCheck = 1'b0;
            checkOutput("launch_data", dac_data_o, curExp.data);
            checkOutput("launch_grant", grant_id_o, curExp.grant);
            checkOutput("start_latency", dac_start_o, 1);
        end
        if (req_ready_o != 2'b00) begin
            launchCount++;
            lastLaunchCycle = cycleCnt;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_launch", req_ready_o, 0);
            end else begin
                curExp = sbQ.pop_front();
                checkOutput("launch_ready", req_ready_o, curExp.ready);
                pendCheck = 1'b1;
            end
        end
        if (tick_overrun_o) begin
            overrunCount++;
            prevOverrun = lastOverrun;
            lastOverrun = cycleCnt;
        end
`ifdef DAC_TIMEOUT_EN
        if (timeout_err_o) begin
            timeoutCount++;
            timeoutCycle = cycleCnt;
        end
`endif
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int relCycle;
        int prevLaunch;
        int setCycle;
        int ovBase;
        int lcBase;
        exp_t e;

        tbl[0] = '{2'b11, 1'b1, 16'h0007};
        tbl[1] = '{2'b11, 1'b0, 16'hFFFB};
        tbl[2] = '{2'b11, 1'b1, 16'h0007};
        tbl[3] = '{2'b11, 1'b0, 16'hFFFB};
        tbl[4] = '{2'b10, 1'b1, 16'h0007};
        tbl[5] = '{2'b10, 1'b1, 16'h0007};
        tbl[6] = '{2'b01, 1'b0, 16'hFFFB};
        tbl[7] = '{2'b01, 1'b0, 16'hFFFB};
        tbl[8] = '{2'b11, 1'b1, 16'h0007};
        tbl[9] = '{2'b11, 1'b0, 16'hFFFB};

        reset_ni    = 1'b0;
        enable_i    = 1'b0;
        req_valid_i = 2'b00;
        req_data_i  = '0;
        dac_idle_i  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", req_ready_o, 0);
        checkOutput("rst_start", dac_start_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_grant", grant_id_o, NUM_REQ - 1);
        checkOutput("rst_overrun", tick_overrun_o, 0);
        checkOutput("rst_data", dac_data_o, 0);
`ifdef DAC_TIMEOUT_EN
        checkOutput("rst_timeout", timeout_err_o, 0);
`endif

        // Single requester: first launch one full tick period after reset release.
        enable_i    = 1'b1;
        req_data_i  = {16'h0000, 16'h1234};
        applyStimulus('{2'b01, 1'b0, 16'h1234});
        @(negedge clk);
        reset_ni = 1'b1;
        relCycle = cycleCnt;
        waitLaunch("first", 3 * RATE_DIV);
        checkOutput("first_launch_cycle", lastLaunchCycle - relCycle, RATE_DIV);
        checkOutput("start_hi_1", dac_start_o, 1);
        @(posedge clk);
        #1;
        checkOutput("start_hi_2", dac_start_o, 1);
        @(posedge clk);
        #1;
        checkOutput("start_dropped", dac_start_o, 0);
        checkOutput("busy_in_busy", busy_o, 1);
        waitIdle("first", 3 * RATE_DIV);

        prevLaunch = lastLaunchCycle;
        applyStimulus('{2'b01, 1'b0, 16'h1234});
        waitLaunch("second", 3 * RATE_DIV);
        checkOutput("second_spacing", lastLaunchCycle - prevLaunch, RATE_DIV);
        waitIdle("second", 3 * RATE_DIV);

        req_data_i = {16'h0007, 16'hFFFB};
        for (int i = 0; i < 10; i++) begin
            prevLaunch = lastLaunchCycle;
            applyStimulus(tbl[i]);
            waitLaunch("table", 3 * RATE_DIV);
            checkOutput("table_spacing", lastLaunchCycle - prevLaunch, RATE_DIV);
            waitIdle("table", 3 * RATE_DIV);
        end

        // Three wraps with nobody valid: the second and third are lost ticks.
        req_valid_i = 2'b00;
        prevLaunch  = lastLaunchCycle;
        ovBase      = overrunCount;
        waitUntilCycle(prevLaunch + 3 * RATE_DIV + 5);
        checkOutput("overrun_count", overrunCount - ovBase, 2);
        checkOutput("overrun_wrap2", prevOverrun - prevLaunch, 2 * RATE_DIV);
        checkOutput("overrun_wrap3", lastOverrun - prevLaunch, 3 * RATE_DIV);
        setCycle = cycleCnt;
        applyStimulus('{2'b10, 1'b1, 16'h0007});
        waitLaunch("late_req", 1);
        checkOutput("late_req_cycle", lastLaunchCycle - setCycle, 0);

        // Disable mid-BUSY: transfer finishes, no new launches, counter restarts from 0.
        prevLaunch = lastLaunchCycle;
        waitUntilCycle(prevLaunch + 5);
        checkOutput("busy_before_disable", busy_o, 1);
        enable_i    = 1'b0;
        req_valid_i = 2'b11;
        waitUntilCycle(prevLaunch + 10);
        checkOutput("busy_after_disable", busy_o, 1);
        waitIdle("disable", 3 * RATE_DIV);
        lcBase = launchCount;
        ovBase = overrunCount;
        repeat (2 * RATE_DIV + 20) @(posedge clk);
        #1;
        checkOutput("disabled_launches", launchCount - lcBase, 0);
        checkOutput("disabled_overruns", overrunCount - ovBase, 0);
        enable_i = 1'b1;
        setCycle = cycleCnt;
        applyStimulus('{2'b11, 1'b0, 16'hFFFB});
        waitLaunch("reenable", 3 * RATE_DIV);
        checkOutput("reenable_cycle", lastLaunchCycle - setCycle, RATE_DIV);

        // Asynchronous reset while in START, between clock edges.
        checkOutput("pre_reset_start", dac_start_o, 1);
        @(negedge clk);
        #2;
        reset_ni = 1'b0;
        #1;
        checkOutput("async_rst_start", dac_start_o, 0);
        checkOutput("async_rst_busy", busy_o, 0);
        checkOutput("async_rst_ready", req_ready_o, 0);
        checkOutput("async_rst_grant", grant_id_o, NUM_REQ - 1);
        repeat (2) @(posedge clk);
        #1;
        reset_ni = 1'b1;
        setCycle = cycleCnt;
        applyStimulus('{2'b11, 1'b0, 16'hFFFB});
        waitLaunch("post_reset", 3 * RATE_DIV);
        checkOutput("post_reset_cycle", lastLaunchCycle - setCycle, RATE_DIV);
        waitIdle("post_reset", 3 * RATE_DIV);

`ifdef DAC_TIMEOUT_EN
        // Writer never leaves idle: START times out, sample dropped, next tick launches.
        wrStuck = 1'b1;
        applyStimulus('{2'b11, 1'b1, 16'h0007});
        waitLaunch("stuck", 3 * RATE_DIV);
        prevLaunch = lastLaunchCycle;
        lcBase     = timeoutCount;
        for (int i = 0; i < 2 * TIMEOUT_CYC; i++) begin
            @(posedge clk);
            #1;
            if (timeoutCount != lcBase) break;
        end
        checkOutput("timeout_pulses", timeoutCount - lcBase, 1);
        checkOutput("timeout_cycle", timeoutCycle - prevLaunch, TIMEOUT_CYC + 1);
        checkOutput("timeout_start", dac_start_o, 0);
        checkOutput("timeout_busy", busy_o, 0);
        wrStuck = 1'b0;
        applyStimulus('{2'b11, 1'b0, 16'hFFFB});
        waitLaunch("after_timeout", 3 * RATE_DIV);
        checkOutput("after_timeout_cycle", lastLaunchCycle - prevLaunch, RATE_DIV);
        waitIdle("after_timeout", 3 * RATE_DIV);
`endif

        checkOutput("total_overruns", overrunCount, 2);
        checkOutput("scoreboard_empty", sbQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
